// File: rtl/pm_mod_reduce.sv
// Pseudo-Mersenne reducer: b = a mod (2^W - C), folding the high half via shift-add over bits of C.
// Define PM_MOD_REDUCE_SKIP_ZERO_EN to step only through the set bits of C (fewer ADD cycles).
module pm_mod_reduce #(
  parameter int unsigned     W  = 256,
  parameter int unsigned     CW = 33,
  parameter logic [CW-1:0]   C  = 33'h1000003D1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] a,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   b
);

  localparam int unsigned IW = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [W-1:0] P = {W{1'b0}} - {{(W-CW){1'b0}}, C};

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSplit = 3'd1;
  localparam logic [2:0] StAdd   = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StSub   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

`ifdef PM_MOD_REDUCE_SKIP_ZERO_EN
  function automatic int first_set_bit();
    int r;
    r = 0;
    for (int i = int'(CW) - 1; i >= 0; i--) if (C[i]) r = i;
    return r;
  endfunction

  function automatic int last_set_bit();
    int r;
    r = 0;
    for (int i = 0; i < int'(CW); i++) if (C[i]) r = i;
    return r;
  endfunction

  localparam logic [IW-1:0] FirstIdx = IW'(first_set_bit());
  localparam logic [IW-1:0] LastIdx  = IW'(last_set_bit());

  // Priority encoder over the constant C: lowest set bit above cur.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    logic [IW-1:0] r;
    r = cur;
    for (int i = int'(CW) - 1; i >= 0; i--) begin
      if (C[i] && (i > int'(cur))) r = IW'(i);
    end
    return r;
  endfunction
`else
  localparam logic [IW-1:0] FirstIdx = '0;
  localparam logic [IW-1:0] LastIdx  = IW'(CW - 1);

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    return cur + 1'b1;
  endfunction
`endif

  logic [2:0]     state_q, state_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   h_q, h_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] h_ext;
  logic [W-1:0]   acc_lo;

  assign h_ext  = {{W{1'b0}}, h_q};
  assign acc_lo = acc_q[W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    h_d     = h_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    b_d     = b_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = a;
          busy_d  = 1'b1;
          state_d = StSplit;
        end
      end
      StSplit: begin
        h_d     = acc_q[2*W-1:W];
        acc_d   = {{W{1'b0}}, acc_lo};
        idx_d   = FirstIdx;
        state_d = StAdd;
      end
      StAdd: begin
        if (C[idx_q]) acc_d = acc_q + (h_ext << idx_q);
        if (idx_q == LastIdx) state_d = StCheck;
        else                  idx_d   = next_idx(idx_q);
      end
      StCheck: begin
        state_d = (acc_q[2*W-1:W] != '0) ? StSplit : StSub;
      end
      StSub: begin
        // acc < 2^W < 2P, so one conditional subtraction lands in [0, P).
        b_d     = (acc_lo >= P) ? (acc_lo - P) : acc_lo;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      h_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      h_q     <= h_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      b_q     <= b_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign b    = b_q;

endmodule

// File: tb/tb_pm_mod_reduce.sv
// Self-checking bench for pm_mod_reduce: secp256k1 defaults plus a small W=16 instance.
module tb_pm_mod_reduce;

  localparam logic [32:0]  CDEF = 33'h1000003D1;
  localparam logic [255:0] PF   = 256'h0 - 256'h1000003D1;
  localparam logic [4:0]   C16  = 5'h11;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [511:0] a;
  logic         busy;
  logic         done;
  logic [255:0] b;

  logic         start16;
  logic [31:0]  a16;
  logic         busy16;
  logic         done16;
  logic [15:0]  b16;

  int n_checks = 0;
  int n_pass   = 0;
  int k_def;
  int k_16;
  logic [255:0] exp_q[$];

  pm_mod_reduce dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .b     (b)
  );

  pm_mod_reduce #(.W(16), .CW(5), .C(C16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .busy  (busy16),
    .done  (done16),
    .b     (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (v[i]) n++;
    return n;
  endfunction

  // Number of fold passes the reduction needs (first pass always runs).
  function automatic int passes256(input logic [511:0] x);
    logic [511:0] acc;
    logic [255:0] h;
    int np;
    acc = x;
    np  = 0;
    do begin
      h   = acc[511:256];
      acc = {256'b0, acc[255:0]} + ({256'b0, h} * {479'b0, CDEF});
      np++;
    end while (acc[511:256] != '0);
    return np;
  endfunction

  function automatic int passes16(input logic [31:0] x);
    logic [31:0] acc;
    int np;
    acc = x;
    np  = 0;
    do begin
      acc = {16'b0, acc[15:0]} + ({16'b0, acc[31:16]} * 32'd17);
      np++;
    end while (acc[31:16] != '0);
    return np;
  endfunction

  function automatic int lat256(input logic [511:0] x);
    return 2 + passes256(x) * (k_def + 2);
  endfunction

  function automatic logic [255:0] ref_mod(input logic [511:0] x);
    logic [511:0] r;
    r = x % {256'b0, PF};
    return r[255:0];
  endfunction

  // Accept edge happens inside; start is dropped just after it.
  task automatic issue(input logic [511:0] x);
    @(negedge clk);
    a     = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
  endtask

  task automatic wait_done(output int lat, output logic [255:0] bo, output bit to,
                           output bit busy_ok);
    lat = 0; bo = '0; to = 1'b1; busy_ok = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n; bo = b; to = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; start16 = 1'b0; a16 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (b !== '0) $display("FAIL reset_b got %h want 0", b); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_one(input string name, input logic [511:0] x, input logic [255:0] want);
    int lat; logic [255:0] bo; bit to, bok; logic [255:0] e;
    exp_q.push_back(want);
    issue(x);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy_accept got %b want 1", name, busy); else n_pass++;
    wait_done(lat, bo, to, bok);
    e = exp_q.pop_front();
    n_checks++;
    if (to) $display("FAIL %s_timeout got no done want done", name);
    else if (bo !== e) $display("FAIL %s_b got %h want %h", name, bo, e);
    else n_pass++;
    n_checks++;
    if (lat !== lat256(x)) $display("FAIL %s_latency got %0d want %0d", name, lat, lat256(x));
    else n_pass++;
    n_checks++;
    if (!bok || busy !== 1'b0)
      $display("FAIL %s_busy got ok=%b end=%b want ok=1 end=0", name, bok, busy);
    else n_pass++;
  endtask

  task automatic test_zero;
    run_one("zero", 512'h0, 256'h0);
  endtask

  task automatic test_p;
    run_one("eq_p", {256'b0, PF}, 256'h0);
  endtask

  task automatic test_pow;
    logic [511:0] x;
    x = '0; x[256] = 1'b1;
    run_one("pow256", x, 256'h1000003D1);
  endtask

  task automatic test_all_ones;
    logic [511:0] x;
    x = '1;
    run_one("all_ones", x, 256'h1000007A2000E90A0);
  endtask

  task automatic test_random;
    logic [511:0] x;
    int lat; logic [255:0] bo; bit to, bok; logic [255:0] e;
    int bad;
    bad = 0;
    for (int t = 0; t < 150; t++) begin
      x = '0;
      for (int j = 0; j < 16; j++) x = {x[479:0], 32'($urandom)};
      if (t % 5 == 0) x[511:256] = 256'($urandom);
      exp_q.push_back(ref_mod(x));
      issue(x);
      wait_done(lat, bo, to, bok);
      e = exp_q.pop_front();
      n_checks++;
      if (to || bo !== e) begin
        $display("FAIL random_%0d got %h want %h", t, bo, e);
        bad++;
      end else n_pass++;
    end
  endtask

  task automatic test_ignore_start;
    logic [511:0] x1;
    logic [255:0] e;
    int lat; logic [255:0] bo; bit to, bok;
    bit seen;
    x1 = {16{32'hDEADBEEF}};
    exp_q.push_back(ref_mod(x1));
    issue(x1);
    seen = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1; bo = b;
        break;
      end
      if (n == 5 || n == 20) begin
        start = 1'b1;
        a     = '1;
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || bo !== e) $display("FAIL ignore_start_b got %h want %h", bo, e); else n_pass++;
    // Back-to-back: start in the done cycle is accepted on the next edge.
    exp_q.push_back(256'h1000003D1);
    a = '0; a[256] = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL back_to_back_accept got busy=%b done=%b want busy=1 done=0", busy, done);
    else n_pass++;
    wait_done(lat, bo, to, bok);
    e = exp_q.pop_front();
    n_checks++;
    if (to || bo !== e) $display("FAIL back_to_back_b got %h want %h", bo, e); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL no_queued_start got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [255:0] bo; bit to, bok;
    issue('1);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || b !== '0)
      $display("FAIL mid_reset got busy=%b done=%b b=%h want 0 0 0", busy, done, b);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    run_one("after_reset", {16{32'h01234567}}, ref_mod({16{32'h01234567}}));
    // Small instance: (2^32-1) mod 65519.
    @(negedge clk);
    a16 = 32'hFFFFFFFF; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    to = 1'b1; lat = 0;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk);
      #1;
      if (done16) begin
        to = 1'b0; lat = n;
        break;
      end
    end
    n_checks++;
    if (to || b16 !== 16'h0120) $display("FAIL w16_b got %h want 0120", b16); else n_pass++;
    n_checks++;
    if (lat !== 2 + passes16(32'hFFFFFFFF) * (k_16 + 2))
      $display("FAIL w16_latency got %0d want %0d", lat,
               2 + passes16(32'hFFFFFFFF) * (k_16 + 2));
    else n_pass++;
  endtask

  initial begin
`ifdef PM_MOD_REDUCE_SKIP_ZERO_EN
    k_def = popcount({31'b0, CDEF});
    k_16  = popcount({59'b0, C16});
`else
    k_def = 33;
    k_16  = 5;
`endif
    test_reset();
    test_zero();
    test_p();
    test_pow();
    test_all_ones();
    test_random();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
